// File: rtl/led_pwm_modulator.sv
// 256-cycle PWM driver for one LED pin, fed by an 8-bit fade ramp.
// Duty and mode are shadowed and reload only at period boundaries; breathe mode mirrors alternate sweeps.
module led_pwm_modulator #(
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] level,
   input  logic [1:0] mode,
   output logic       pwm_out,
   output logic       period_start,
   output logic [7:0] duty,
   output logic       sweep_dir
);

   localparam logic INACTIVE = ~ACTIVE_HIGH;

   logic [7:0] r_cnt;
   logic [7:0] r_duty;
   logic [1:0] r_mode_q;
   logic [7:0] r_level_prev;
   logic       r_sweep_dir;
   logic       r_period_start;
   logic       r_pwm_out;

   logic       w_wrap;
   logic       w_dir_next;
   logic [7:0] w_target;
   logic       w_load;
   logic       w_raw;

   // A falling level means the upstream ramp wrapped; that flips the breathe direction.
   assign w_wrap     = (level < r_level_prev);
   assign w_dir_next = w_wrap ? ~r_sweep_dir : r_sweep_dir;
   assign w_target   = ((mode == 2'b01) && w_dir_next) ? (8'd255 - level) : level;
   assign w_load     = enable && (r_cnt == 8'd255);

   always_comb begin
      w_raw = 1'b0;
      case (r_mode_q)
         2'b00, 2'b01: w_raw = (r_cnt < r_duty);
         2'b10:        w_raw = 1'b0;
         default:      w_raw = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt          <= 8'd0;
         r_duty         <= 8'd0;
         r_mode_q       <= 2'b00;
         r_level_prev   <= 8'd0;
         r_sweep_dir    <= 1'b0;
         r_period_start <= 1'b0;
         r_pwm_out      <= INACTIVE;
      end else begin
         r_level_prev   <= level;
         r_sweep_dir    <= w_dir_next;
         r_period_start <= w_load;
         if (enable) begin
            r_cnt     <= r_cnt + 8'd1;
            r_pwm_out <= w_raw ^ INACTIVE;
         end else begin
            r_pwm_out <= INACTIVE;
         end
         if (w_load) begin
            r_duty   <= w_target;
            r_mode_q <= mode;
         end
      end
   end

   assign pwm_out      = r_pwm_out;
   assign period_start = r_period_start;
   assign duty         = r_duty;
   assign sweep_dir    = r_sweep_dir;

endmodule

// File: tb/tb_led_pwm_modulator.sv
// Scoreboard bench for led_pwm_modulator: both output polarities run side by side against
// a period-oriented reference model; a negedge monitor pops and checks every cycle.
module tb_led_pwm_modulator;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] level;
   logic [1:0] mode;
   logic       pwm_h, ps_h, dir_h;
   logic [7:0] duty_h;
   logic       pwm_l, ps_l, dir_l;
   logic [7:0] duty_l;

   logic [11:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // reference model state, in terms of the period position and the applied settings
   int   m_pos;
   int   m_duty;
   int   m_mode;
   int   m_prev;
   bit   m_dir;
   bit   m_ps;
   bit   m_on;

   led_pwm_modulator #(.ACTIVE_HIGH(1'b1)) dut_h (
      .clk(clk), .rst(rst), .enable(enable), .level(level), .mode(mode),
      .pwm_out(pwm_h), .period_start(ps_h), .duty(duty_h), .sweep_dir(dir_h)
   );

   led_pwm_modulator #(.ACTIVE_HIGH(1'b0)) dut_l (
      .clk(clk), .rst(rst), .enable(enable), .level(level), .mode(mode),
      .pwm_out(pwm_l), .period_start(ps_l), .duty(duty_l), .sweep_dir(dir_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one clock of stimulus; expected post-edge outputs are queued at the edge
   task automatic step(input bit r, input bit e, input int l, input int m);
      bit dir_after;
      rst    = r;
      enable = e;
      level  = 8'(l);
      mode   = 2'(m);
      if (r) begin
         m_pos = 0; m_duty = 0; m_mode = 0; m_prev = 0; m_dir = 0; m_ps = 0; m_on = 0;
      end else begin
         // lit if this period position falls inside the active part of the period
         if (m_mode == 3)      m_on = e;
         else if (m_mode == 2) m_on = 0;
         else                  m_on = e && (m_pos < m_duty);
         dir_after = (l < m_prev) ? !m_dir : m_dir;
         m_ps = e && (m_pos == 255);
         if (m_ps) begin
            m_duty = (m == 1 && dir_after) ? 255 - l : l;
            m_mode = m;
         end
         if (e) m_pos = (m_pos + 1) % 256;
         m_prev = l;
         m_dir  = dir_after;
      end
      @(posedge clk);
      exp_q.push_back({m_on, !m_on, m_ps, m_dir, 8'(m_duty)});
      #1;
   endtask

   always @(negedge clk) begin
      logic [11:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({pwm_h, pwm_l, ps_h, dir_h, duty_h} !== e ||
             ps_l !== e[9] || dir_l !== e[8] || duty_l !== e[7:0]) begin
            errors++;
            if (errors <= 20)
               $display("FAIL outputs t=%0t got pwm_h=%b pwm_l=%b ps=%b/%b dir=%b/%b duty=%0d/%0d want pwm_h=%b pwm_l=%b ps=%b dir=%b duty=%0d",
                        $time, pwm_h, pwm_l, ps_h, ps_l, dir_h, dir_l, duty_h, duty_l,
                        e[11], e[10], e[9], e[8], e[7:0]);
         end
      end
   end

   initial begin
      int lv;
      int md;
      rst = 1'b1; enable = 1'b0; level = 8'd0; mode = 2'b00;
      repeat (3) step(1, 0, 128, 0);

      // direct mode, steady 128: dark first period, then half duty
      repeat (600) step(0, 1, 128, 0);
      // level change mid-period takes effect only at next boundary
      repeat (3) step(1, 1, 64, 0);
      repeat (356) step(0, 1, 64, 0);
      repeat (400) step(0, 1, 200, 0);

      // breathe mode on a repeating ramp, including 250..255 then 0..10 wraps
      for (int i = 0; i < 1100; i++) step(0, 1, (i + 3) % 256, 1);

      // boundary duties and forced modes
      repeat (520) step(0, 1, 0, 0);
      repeat (520) step(0, 1, 255, 0);
      repeat (520) step(0, 1, 77, 3);
      repeat (520) step(0, 1, 77, 2);

      // enable gap of 50 cycles at cnt 40
      repeat (3) step(1, 1, 32, 0);
      repeat (256 + 41) step(0, 1, 32, 0);
      repeat (50) step(0, 0, 32, 0);
      repeat (400) step(0, 1, 32, 0);

      // randomized mix with occasional mid-period reset
      lv = 0; md = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) md = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) lv = $urandom_range(0, 255);
         else                           lv = (lv + 1) % 256;
         step((i == 1500) ? 1'b1 : 1'b0, $urandom_range(0, 9) != 0, lv, md);
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
